// File: rtl/onehot_label_streamer.sv
// Expands a class index into a DIM-element one-hot target vector and streams it one element per beat.
// Optional build macro LABEL_SMOOTH_EN replaces the hot/cold constants with label-smoothed values.
module onehot_label_streamer #(
  parameter int DATA_W     = 32,
  parameter int DIM        = 10,
  parameter int HOT_VAL    = 65536,
  parameter int COLD_VAL   = 0,
  parameter int SMOOTH_EPS = 6554,
  localparam int IDX_W     = $clog2(DIM)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [IDX_W-1:0]         idx_in,
  input  logic                     idx_valid,
  output logic                     idx_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]         out_pos,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     err_range,
  output logic [15:0]              frame_cnt
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_STREAM = 1'b1;

`ifdef LABEL_SMOOTH_EN
  // Smoothing mass is taken from the hot class and spread evenly over the DIM-1 cold classes.
  localparam int HOT_INT  = HOT_VAL - SMOOTH_EPS;
  localparam int COLD_INT = COLD_VAL + (SMOOTH_EPS / (DIM - 1));
`else
  localparam int HOT_INT  = HOT_VAL;
  localparam int COLD_INT = COLD_VAL;
`endif

  localparam logic signed [DATA_W-1:0] HOT_C  = DATA_W'(HOT_INT);
  localparam logic signed [DATA_W-1:0] COLD_C = DATA_W'(COLD_INT);
  localparam logic [IDX_W:0]           DIM_C  = (IDX_W + 1)'(DIM);
  localparam logic [IDX_W-1:0]         LAST_C = IDX_W'(DIM - 1);

  logic [0:0]               state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [IDX_W-1:0]         pos_q, pos_d;
  logic signed [DATA_W-1:0] data_q, data_d;
  logic                     valid_q, valid_d;
  logic                     last_q, last_d;
  logic                     err_q, err_d;
  logic [15:0]              frame_q, frame_d;
  logic [IDX_W-1:0]         pos_nxt;

  assign idx_ready = (state_q == S_IDLE) && !rst;
  assign pos_nxt   = pos_q + 1'b1;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path can infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    pos_d   = pos_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    err_d   = 1'b0;
    frame_d = frame_q;
    case (state_q)
      S_IDLE: begin
        if (idx_valid) begin
          if ({1'b0, idx_in} < DIM_C) begin
            idx_d   = idx_in;
            pos_d   = '0;
            data_d  = (idx_in == '0) ? HOT_C : COLD_C;
            last_d  = 1'b0;
            valid_d = 1'b1;
            state_d = S_STREAM;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: begin
        // Outputs only move on an accepted beat, so a stalled beat holds stable.
        if (out_ready) begin
          if (last_q) begin
            frame_d = frame_q + 16'd1;
            valid_d = 1'b0;
            last_d  = 1'b0;
            pos_d   = '0;
            data_d  = '0;
            state_d = S_IDLE;
          end else begin
            pos_d  = pos_nxt;
            data_d = (pos_nxt == idx_q) ? HOT_C : COLD_C;
            last_d = (pos_nxt == LAST_C);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      pos_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pos_q   <= pos_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      err_q   <= err_d;
      frame_q <= frame_d;
    end
  end

  assign out_data  = data_q;
  assign out_pos   = pos_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign err_range = err_q;
  assign frame_cnt = frame_q;

endmodule
